// File: rtl/id_ex_pipe_reg.sv
// ID->EXE pipeline register with valid/ready handshake, synchronous flush and an
// optional one-entry skid buffer (SKID=1) so stalls do not cost a bubble.
module id_ex_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 4,
    parameter int CMD_W  = 4,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        ctrl_in,
    input  logic [CMD_W-1:0]  exe_cmd_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] val_rn_in,
    input  logic [DATA_W-1:0] val_rm_in,
    input  logic [REG_W-1:0]  dest_in,
    input  logic [REG_W-1:0]  src1_in,
    input  logic [REG_W-1:0]  src2_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [3:0]        sr_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        ctrl_out,
    output logic [CMD_W-1:0]  exe_cmd_out,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] val_rn_out,
    output logic [DATA_W-1:0] val_rm_out,
    output logic [REG_W-1:0]  dest_out,
    output logic [REG_W-1:0]  src1_out,
    output logic [REG_W-1:0]  src2_out,
    output logic              imm_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       signed_imm_24_out,
    output logic [3:0]        sr_out,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_count
);

    localparam int CTL_W = 5 + CMD_W;
    localparam int PW    = CTL_W + 3*DATA_W + 3*REG_W + 1 + 12 + 24 + 4;

    logic [PW-1:0]    w_in_pl;
    logic [PW-1:0]    r_m_pl;
    logic [PW-1:0]    r_k_pl;
    logic             r_m_v;
    logic             r_k_v;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_in_fire;
    logic             w_accept;
    logic             w_out_fire;
    logic [1:0]       w_held;
    logic [4:0]       w_ctrl;
    logic [CMD_W-1:0] w_cmd;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    assign w_in_pl = {ctrl_in, exe_cmd_in, pc_in, val_rn_in, val_rm_in,
                      dest_in, src1_in, src2_in, imm_in, shift_operand_in,
                      signed_imm_24_in, sr_in};

    // With the skid entry, ready depends only on held state, breaking the out_ready path.
    assign in_ready   = (SKID != 0) ? !r_k_v : (!r_m_v | out_ready);
    assign w_in_fire  = in_valid & in_ready;
    assign w_accept   = w_in_fire & !flush;
    assign w_out_fire = r_m_v & out_ready;
    assign w_held     = {1'b0, r_m_v} + {1'b0, r_k_v};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_v       <= 1'b0;
            r_k_v       <= 1'b0;
            r_m_pl      <= '0;
            r_k_pl      <= '0;
            r_flush_cnt <= '0;
        end else if (flush) begin
            r_m_v                    <= 1'b0;
            r_k_v                    <= 1'b0;
            r_m_pl[PW-1 -: CTL_W]    <= '0;
            r_k_pl[PW-1 -: CTL_W]    <= '0;
            r_flush_cnt              <= sat_add(r_flush_cnt, w_held);
        end else if (SKID != 0) begin
            if (!r_m_v || w_out_fire) begin
                if (r_k_v) begin
                    r_m_pl <= r_k_pl;
                    r_m_v  <= 1'b1;
                    r_k_v  <= w_accept;
                    if (w_accept)
                        r_k_pl <= w_in_pl;
                end else if (w_accept) begin
                    r_m_pl <= w_in_pl;
                    r_m_v  <= 1'b1;
                end else begin
                    r_m_v  <= 1'b0;
                end
            end else if (w_accept) begin
                r_k_pl <= w_in_pl;
                r_k_v  <= 1'b1;
            end
        end else begin
            if (w_accept) begin
                r_m_pl <= w_in_pl;
                r_m_v  <= 1'b1;
            end else if (w_out_fire) begin
                r_m_v  <= 1'b0;
            end
        end
    end

    assign {w_ctrl, w_cmd, pc_out, val_rn_out, val_rm_out, dest_out, src1_out,
            src2_out, imm_out, shift_operand_out, signed_imm_24_out, sr_out} = r_m_pl;

    // A bubble must never write back or touch memory, whatever stale payload it holds.
    assign ctrl_out    = r_m_v ? w_ctrl : 5'd0;
    assign exe_cmd_out = r_m_v ? w_cmd : {CMD_W{1'b0}};
    assign out_valid   = r_m_v;
    assign occupancy   = w_held;
    assign flush_count = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: a SKID=1 and a SKID=0 (2-bit flush counter) instance share
// stimulus; each is scored against a FIFO-queue model of its capacity.
module tb_id_ex_pipe_reg;

    localparam int PW = 5 + 4 + 3*32 + 3*4 + 1 + 12 + 24 + 4;
    typedef logic [PW-1:0] pl_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush, in_valid, out_ready, imm_in;
    logic [4:0]  ctrl_in;
    logic [3:0]  exe_cmd_in, dest_in, src1_in, src2_in, sr_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic [11:0] shift_operand_in;
    logic [23:0] signed_imm_24_in;

    logic        in_ready1, out_valid1, imm_out1;
    logic [4:0]  ctrl_out1;
    logic [3:0]  exe_cmd_out1, dest_out1, src1_out1, src2_out1, sr_out1;
    logic [31:0] pc_out1, val_rn_out1, val_rm_out1;
    logic [11:0] shift_operand_out1;
    logic [23:0] signed_imm_24_out1;
    logic [1:0]  occupancy1;
    logic [15:0] flush_count1;

    logic        in_ready0, out_valid0, imm_out0;
    logic [4:0]  ctrl_out0;
    logic [3:0]  exe_cmd_out0, dest_out0, src1_out0, src2_out0, sr_out0;
    logic [31:0] pc_out0, val_rn_out0, val_rm_out0;
    logic [11:0] shift_operand_out0;
    logic [23:0] signed_imm_24_out0;
    logic [1:0]  occupancy0;
    logic [1:0]  flush_count0;

    pl_t o1, o0;
    pl_t q1[$];
    pl_t q0[$];
    int  cnt1, cnt0;
    int  n_tests = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;
    bit  pend_fl, pend_acc1, pend_acc0;
    int  pend_sz1, pend_sz0;
    pl_t pend_pl;

    always #5 clk = ~clk;

    id_ex_pipe_reg #(.DATA_W(32), .REG_W(4), .CMD_W(4), .SKID(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
        .ctrl_in(ctrl_in), .exe_cmd_in(exe_cmd_in), .pc_in(pc_in), .val_rn_in(val_rn_in),
        .val_rm_in(val_rm_in), .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
        .imm_in(imm_in), .shift_operand_in(shift_operand_in),
        .signed_imm_24_in(signed_imm_24_in), .sr_in(sr_in),
        .out_valid(out_valid1), .out_ready(out_ready), .ctrl_out(ctrl_out1),
        .exe_cmd_out(exe_cmd_out1), .pc_out(pc_out1), .val_rn_out(val_rn_out1),
        .val_rm_out(val_rm_out1), .dest_out(dest_out1), .src1_out(src1_out1),
        .src2_out(src2_out1), .imm_out(imm_out1), .shift_operand_out(shift_operand_out1),
        .signed_imm_24_out(signed_imm_24_out1), .sr_out(sr_out1),
        .occupancy(occupancy1), .flush_count(flush_count1));

    id_ex_pipe_reg #(.DATA_W(32), .REG_W(4), .CMD_W(4), .SKID(0), .CNT_W(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
        .ctrl_in(ctrl_in), .exe_cmd_in(exe_cmd_in), .pc_in(pc_in), .val_rn_in(val_rn_in),
        .val_rm_in(val_rm_in), .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in),
        .imm_in(imm_in), .shift_operand_in(shift_operand_in),
        .signed_imm_24_in(signed_imm_24_in), .sr_in(sr_in),
        .out_valid(out_valid0), .out_ready(out_ready), .ctrl_out(ctrl_out0),
        .exe_cmd_out(exe_cmd_out0), .pc_out(pc_out0), .val_rn_out(val_rn_out0),
        .val_rm_out(val_rm_out0), .dest_out(dest_out0), .src1_out(src1_out0),
        .src2_out(src2_out0), .imm_out(imm_out0), .shift_operand_out(shift_operand_out0),
        .signed_imm_24_out(signed_imm_24_out0), .sr_out(sr_out0),
        .occupancy(occupancy0), .flush_count(flush_count0));

    assign o1 = {ctrl_out1, exe_cmd_out1, pc_out1, val_rn_out1, val_rm_out1, dest_out1,
                 src1_out1, src2_out1, imm_out1, shift_operand_out1, signed_imm_24_out1, sr_out1};
    assign o0 = {ctrl_out0, exe_cmd_out0, pc_out0, val_rn_out0, val_rm_out0, dest_out0,
                 src1_out0, src2_out0, imm_out0, shift_operand_out0, signed_imm_24_out0, sr_out0};

    task automatic chk(input string nm, input pl_t act, input pl_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic pl_t make_pl();
        return {ctrl_in, exe_cmd_in, pc_in, val_rn_in, val_rm_in, dest_in, src1_in,
                src2_in, imm_in, shift_operand_in, signed_imm_24_in, sr_in};
    endfunction

    // Monitor: compares both DUTs against their queues, pops on a consume.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("s1_valid", pl_t'(out_valid1), pl_t'(q1.size() > 0));
            chk("s1_occ", pl_t'(occupancy1), pl_t'(q1.size()));
            chk("s1_in_ready", pl_t'(in_ready1), pl_t'(q1.size() < 2));
            chk("s1_flush_count", pl_t'(flush_count1), pl_t'(cnt1));
            if (q1.size() > 0) chk("s1_payload", o1, q1[0]);
            else               chk("s1_bubble_ctrl", pl_t'({ctrl_out1, exe_cmd_out1}), '0);
            if (out_ready && !flush && q1.size() > 0) void'(q1.pop_front());

            chk("s0_valid", pl_t'(out_valid0), pl_t'(q0.size() > 0));
            chk("s0_occ", pl_t'(occupancy0), pl_t'(q0.size()));
            chk("s0_in_ready", pl_t'(in_ready0), pl_t'(q0.size() == 0 || out_ready));
            chk("s0_flush_count", pl_t'(flush_count0), pl_t'(cnt0));
            if (q0.size() > 0) chk("s0_payload", o0, q0[0]);
            else               chk("s0_bubble_ctrl", pl_t'({ctrl_out0, exe_cmd_out0}), '0);
            if (out_ready && !flush && q0.size() > 0) void'(q0.pop_front());
        end
    end

    // Applies the previous cycle's issue to the model at the edge, then drives the next one.
    task automatic step(input logic iv, input logic [31:0] pc, input logic [4:0] ct,
                        input logic ordy, input logic fl);
        @(posedge clk);
        if (pend_fl) begin
            cnt1 = (cnt1 + pend_sz1 > 65535) ? 65535 : cnt1 + pend_sz1;
            cnt0 = (cnt0 + pend_sz0 > 3) ? 3 : cnt0 + pend_sz0;
            q1.delete();
            q0.delete();
        end else begin
            if (pend_acc1) q1.push_back(pend_pl);
            if (pend_acc0) q0.push_back(pend_pl);
        end
        #1;
        in_valid         = iv;
        pc_in            = pc;
        ctrl_in          = ct;
        exe_cmd_in       = 4'($urandom);
        val_rn_in        = $urandom;
        val_rm_in        = $urandom;
        dest_in          = 4'($urandom);
        src1_in          = 4'($urandom);
        src2_in          = 4'($urandom);
        imm_in           = 1'($urandom);
        shift_operand_in = 12'($urandom);
        signed_imm_24_in = 24'($urandom);
        sr_in            = 4'($urandom);
        out_ready        = ordy;
        flush            = fl;
        pend_fl   = fl;
        pend_sz1  = q1.size();
        pend_sz0  = q0.size();
        pend_acc1 = iv && (q1.size() < 2) && !fl;
        pend_acc0 = iv && (q0.size() == 0 || ordy) && !fl;
        pend_pl   = make_pl();
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {flush, in_valid, out_ready, imm_in, ctrl_in, exe_cmd_in, dest_in, src1_in, src2_in} = '0;
        {sr_in, pc_in, val_rn_in, val_rm_in, shift_operand_in, signed_imm_24_in} = '0;
        cnt1 = 0; cnt0 = 0;
        pend_fl = 0; pend_acc1 = 0; pend_acc0 = 0; pend_sz1 = 0; pend_sz0 = 0; pend_pl = '0;
        #12;
        chk("rst_valid", pl_t'(out_valid1), '0);
        chk("rst_occ", pl_t'(occupancy1), '0);
        chk("rst_fcnt", pl_t'(flush_count1), '0);
        chk("rst_payload", o1, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", pl_t'(in_ready1), pl_t'(1));
        chk("rst_in_ready0", pl_t'(in_ready0), pl_t'(1));
        chk_en = 1'b1;

        // Bubble gating
        step(1'b0, 32'd0, 5'b11111, 1'b1, 1'b0);
        step(1'b0, 32'd0, 5'b11111, 1'b1, 1'b0);
        chk("bubble_valid", pl_t'(out_valid1), '0);
        chk("bubble_ctrl", pl_t'(ctrl_out1), '0);
        chk("bubble_cmd", pl_t'(exe_cmd_out1), '0);

        // Streaming
        for (int i = 0; i < 5; i++) begin
            step(i < 4, 32'(4 * (i + 1)), 5'($urandom), 1'b1, 1'b0);
            if (i > 0) begin
                chk("stream_valid", pl_t'(out_valid1), pl_t'(1));
                chk("stream_pc", pl_t'(pc_out1), pl_t'(4 * i));
                chk("stream_occ_le1", pl_t'(occupancy1 <= 2'd1), pl_t'(1));
            end
        end
        step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0);

        // Stall with skid capture
        step(1'b1, 32'd4, 5'($urandom), 1'b1, 1'b0);
        step(1'b1, 32'd8, 5'($urandom), 1'b0, 1'b0);
        chk("stall_pc_a", pl_t'(pc_out1), pl_t'(4));
        step(1'b1, 32'd12, 5'($urandom), 1'b0, 1'b0);
        chk("stall_occ2", pl_t'(occupancy1), pl_t'(2));
        chk("stall_in_ready", pl_t'(in_ready1), '0);
        chk("stall_pc_b", pl_t'(pc_out1), pl_t'(4));
        step(1'b1, 32'd12, 5'($urandom), 1'b0, 1'b0);
        step(1'b1, 32'd12, 5'($urandom), 1'b1, 1'b0);
        chk("stall_pc_c", pl_t'(pc_out1), pl_t'(4));
        step(1'b1, 32'd12, 5'($urandom), 1'b1, 1'b0);
        chk("release_pc8", pl_t'(pc_out1), pl_t'(8));
        step(1'b1, 32'd16, 5'($urandom), 1'b1, 1'b0);
        chk("release_pc12", pl_t'(pc_out1), pl_t'(12));
        step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
        chk("release_pc16", pl_t'(pc_out1), pl_t'(16));
        step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
        chk("release_empty", pl_t'(out_valid1), '0);

        // Flush with both entries held
        step(1'b1, 32'h40, 5'b10000, 1'b0, 1'b0);
        step(1'b1, 32'h44, 5'b10000, 1'b0, 1'b0);
        step(1'b1, 32'h48, 5'b10000, 1'b0, 1'b1);
        step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
        chk("flush_valid", pl_t'(out_valid1), '0);
        chk("flush_ctrl", pl_t'(ctrl_out1), '0);
        chk("flush_occ", pl_t'(occupancy1), '0);
        chk("flush_count2", pl_t'(flush_count1), pl_t'(2));
        chk("flush_in_ready", pl_t'(in_ready1), pl_t'(1));

        // Single-register build: ready follows out_ready in the same cycle
        step(1'b1, 32'h200, 5'($urandom), 1'b0, 1'b0);
        step(1'b1, 32'h204, 5'($urandom), 1'b0, 1'b0);
        chk("s0_stall_ready", pl_t'(in_ready0), '0);
        chk("s0_stall_pc", pl_t'(pc_out0), pl_t'(32'h200));
        step(1'b1, 32'h208, 5'($urandom), 1'b1, 1'b0);
        chk("s0_ready_follow", pl_t'(in_ready0), pl_t'(1));
        step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
        chk("s0_same_edge_pc", pl_t'(pc_out0), pl_t'(32'h208));
        chk("s0_same_edge_valid", pl_t'(out_valid0), pl_t'(1));

        // Randomized traffic
        for (int i = 0; i < 600; i++)
            step(($urandom % 4) != 0, $urandom, 5'($urandom), ($urandom % 3) != 0,
                 ($urandom % 16) == 0);

        // Asynchronous reset mid-stall
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
        step(1'b1, 32'h300, 5'b11111, 1'b1, 1'b0);
        step(1'b1, 32'h304, 5'b11111, 1'b0, 1'b0);
        step(1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        chk("pre_rst_occ2", pl_t'(occupancy1), pl_t'(2));
        chk_en = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", pl_t'(out_valid1), '0);
        chk("arst_occ", pl_t'(occupancy1), '0);
        chk("arst_payload", o1, '0);
        chk("arst_fcnt", pl_t'(flush_count1), '0);
        chk("arst_valid0", pl_t'(out_valid0), '0);
        chk("arst_fcnt0", pl_t'(flush_count0), '0);
        q1.delete(); q0.delete();
        cnt1 = 0; cnt0 = 0;
        pend_fl = 0; pend_acc1 = 0; pend_acc0 = 0;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("arst_in_ready", pl_t'(in_ready1), pl_t'(1));
        chk("arst_occ_after", pl_t'(occupancy1), '0);
        chk_en = 1'b1;
        step(1'b1, 32'h100, 5'($urandom), 1'b1, 1'b0);
        step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
        chk("post_rst_pc", pl_t'(pc_out1), pl_t'(32'h100));
        chk("post_rst_valid", pl_t'(out_valid1), pl_t'(1));
        step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
        step(1'b0, 32'd0, 5'd0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
